// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX buffer stream among NUM_REQ byte requesters, locked per packet or MAX_BURST beats.
// Latency: zero-cycle combinational pass-through per beat, one idle arbitration cycle between consecutive grants.
// Backpressure: i_txb_tready is forwarded only to the owner; optional stall release via `UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int UART_DLEN      = 8,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i_req_tvalid,
    output logic [NUM_REQ-1:0]             o_req_tready,
    input  logic [NUM_REQ*UART_DLEN-1:0]   i_req_tdata,
    input  logic [NUM_REQ-1:0]             i_req_tlast,
    output logic                           o_txb_tvalid,
    input  logic                           i_txb_tready,
    output logic [UART_DLEN-1:0]           o_txb_tdata,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic [UART_DLEN-1:0] hold_dat_q, hold_dat_d;
    logic                 timeout_q, timeout_d;

    logic                 live;
    logic                 beat;
    logic                 release_lock;
    logic                 own_vld;
    logic                 own_last;
    logic [UART_DLEN-1:0] own_dat;
    logic                 found;
    int                   idx;

    // Reset gates every output so no beat can complete in a reset cycle.
    assign live = (state_q == GRANT) && !rst;
    assign beat = live && own_vld && i_txb_tready;

    always_comb begin
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_dat  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_q == PW'(r)) begin
                own_vld  = i_req_tvalid[r];
                own_last = i_req_tlast[r];
                own_dat  = i_req_tdata[r*UART_DLEN +: UART_DLEN];
            end
        end
    end

    assign o_txb_tvalid = live && own_vld;
    assign o_txb_tdata  = rst ? '0 : (live ? own_dat : hold_dat_q);
    assign o_req_tready = live ? (grant_q & {NUM_REQ{i_txb_tready}}) : '0;
    assign o_grant      = rst ? '0 : grant_q;
    assign o_busy       = live;
    assign o_timeout    = timeout_q && !rst;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        stall_d      = stall_q;
        timeout_d    = timeout_q;
        hold_dat_d   = live ? own_dat : hold_dat_q;
        release_lock = 1'b0;
        found        = 1'b0;
        idx          = 0;
        case (state_q)
            IDLE: begin
                if (|i_req_tvalid) begin
                    // First valid requester at or after rr_ptr, wrapping.
                    for (int i = 0; i < NUM_REQ; i++) begin
                        idx = (int'(rr_ptr_q) + i) % NUM_REQ;
                        if (!found && i_req_tvalid[idx]) begin
                            found        = 1'b1;
                            owner_d      = PW'(idx);
                            grant_d      = '0;
                            grant_d[idx] = 1'b1;
                        end
                    end
                    state_d    = GRANT;
                    beat_cnt_d = '0;
                    stall_d    = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (own_last || beat_cnt_q == BW'(MAX_BURST - 1)) begin
                        release_lock = 1'b1;
                    end
                end
                if (TIMEOUT_EN) begin
                    if (beat) begin
                        stall_d = '0;
                    end else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                        release_lock = 1'b1;
                        timeout_d    = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                if (release_lock) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            stall_q    <= '0;
            timeout_q  <= 1'b0;
            hold_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
            hold_dat_q <= hold_dat_d;
        end
    end

endmodule
